// File: rtl/edge_sync_if.sv
// Bundles the per-channel level inputs, edge enables, clears and event/count
// outputs of edge_sync.
interface edge_sync_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0]       i;
  logic [WIDTH-1:0]       rise_en;
  logic [WIDTH-1:0]       fall_en;
  logic [WIDTH-1:0]       clr;
  logic [WIDTH-1:0]       level;
  logic [WIDTH-1:0]       o;
  logic [WIDTH*CNT_W-1:0] count;
  logic [WIDTH-1:0]       ovf;

  modport master (
    output i, rise_en, fall_en, clr,
    input  level, o, count, ovf
  );

  modport slave (
    input  i, rise_en, fall_en, clr,
    output level, o, count, ovf
  );
endinterface

// File: rtl/edge_sync.sv
// Multi-channel synchronizer for raw asynchronous levels: sync chain, optional
// glitch filter, selectable edge events and saturating per-channel event counters.
module edge_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILTER = 0,
  parameter int unsigned CNT_W  = 8
) (
  input logic       clk,
  input logic       reset_l,
  edge_sync_if.slave bus
);

  localparam int unsigned FEff  = (FILTER < 2) ? 1 : FILTER;
  localparam int unsigned FCntW = (FEff > 1) ? $clog2(FEff) : 1;
  localparam logic [FCntW-1:0] FLast  = FCntW'(FEff - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [STAGES-1:0] r_sync  [WIDTH];
  logic [FCntW-1:0]  r_fcnt  [WIDTH];
  logic [CNT_W-1:0]  r_count [WIDTH];
  logic [WIDTH-1:0]  r_level;
  logic [WIDTH-1:0]  r_o;
  logic [WIDTH-1:0]  r_ovf;

  logic [WIDTH-1:0]       w_s;
  logic [WIDTH-1:0]       w_level_d;
  logic [WIDTH-1:0]       w_o_d;
  logic [WIDTH-1:0]       w_ovf_d;
  logic [FCntW-1:0]       w_fcnt_d  [WIDTH];
  logic [CNT_W-1:0]       w_count_d [WIDTH];
  logic [WIDTH*CNT_W-1:0] w_count_flat;

  always_comb begin
    w_s       = '0;
    w_level_d = r_level;
    w_o_d     = '0;
    w_ovf_d   = r_ovf;
    for (int n = 0; n < WIDTH; n++) begin
      w_fcnt_d[n]  = '0;
      w_count_d[n] = r_count[n];
    end

    for (int n = 0; n < WIDTH; n++) begin
      w_s[n] = r_sync[n][STAGES-1];

      // Level only moves after FEff consecutive samples disagree with it.
      if (FEff == 1) begin
        w_level_d[n] = w_s[n];
      end else if (w_s[n] != r_level[n]) begin
        if (r_fcnt[n] == FLast) begin
          w_level_d[n] = w_s[n];
        end else begin
          w_fcnt_d[n] = r_fcnt[n] + 1'b1;
        end
      end

      w_o_d[n] = (w_level_d[n] & ~r_level[n] & bus.rise_en[n]) |
                 (~w_level_d[n] & r_level[n] & bus.fall_en[n]);

      // A clear coinciding with an event still counts that event.
      if (r_o[n]) begin
        if (bus.clr[n]) begin
          w_count_d[n] = CNT_W'(1);
          w_ovf_d[n]   = 1'b0;
        end else if (r_count[n] == CntMax) begin
          w_ovf_d[n] = 1'b1;
        end else begin
          w_count_d[n] = r_count[n] + 1'b1;
        end
      end else if (bus.clr[n]) begin
        w_count_d[n] = '0;
        w_ovf_d[n]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int n = 0; n < WIDTH; n++) begin
        r_sync[n]  <= '0;
        r_fcnt[n]  <= '0;
        r_count[n] <= '0;
      end
      r_level <= '0;
      r_o     <= '0;
      r_ovf   <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        r_sync[n]  <= {r_sync[n][STAGES-2:0], bus.i[n]};
        r_fcnt[n]  <= w_fcnt_d[n];
        r_count[n] <= w_count_d[n];
      end
      r_level <= w_level_d;
      r_o     <= w_o_d;
      r_ovf   <= w_ovf_d;
    end
  end

  always_comb begin
    w_count_flat = '0;
    for (int n = 0; n < WIDTH; n++) begin
      w_count_flat[n*CNT_W +: CNT_W] = r_count[n];
    end
  end

  assign bus.level = r_level;
  assign bus.o     = r_o;
  assign bus.ovf   = r_ovf;
  assign bus.count = w_count_flat;

endmodule
